// File: rtl/ram_stream_writer.sv
// Streams words into RAM port A from a base address, one registered write per accepted beat.
// Tracks word count and a modular checksum; supports abort and zero-length transfers.
module ram_stream_writer #(
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   input  logic                  abort,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_wren,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   words_written,
   output logic [DATA_WIDTH-1:0] checksum
);

   typedef enum logic [1:0] {IDLE, WRITE, FLUSH} state_t;

   localparam logic [ADDR_WIDTH:0] ONE = 1;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH:0]   len_q;
   logic                  beat;
   logic                  last_beat;

   assign in_ready  = (state == WRITE) && !abort;
   assign beat      = in_valid && in_ready;
   // words_written never exceeds len_q, so the increment cannot overflow its width
   assign last_beat = beat && ((words_written + ONE) == len_q);
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start && (length != '0)) state_nxt = WRITE;
         WRITE:   if (abort) state_nxt = IDLE;
                  else if (last_beat) state_nxt = FLUSH;
         FLUSH:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         base_q        <= '0;
         len_q         <= '0;
         ram_address   <= '0;
         ram_data      <= '0;
         ram_wren      <= 1'b0;
         done          <= 1'b0;
         words_written <= '0;
         checksum      <= '0;
      end else begin
         ram_wren <= beat;
         done     <= 1'b0;
         if (beat) begin
            // address wraps naturally by truncation to ADDR_WIDTH bits
            ram_address   <= base_q + words_written[ADDR_WIDTH-1:0];
            ram_data      <= in_data;
            words_written <= words_written + ONE;
            checksum      <= checksum + in_data;
         end
         if (state == IDLE && start) begin
            base_q        <= base_addr;
            len_q         <= length;
            words_written <= '0;
            checksum      <= '0;
            done          <= (length == '0);
         end
         if (state == FLUSH) done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ram_stream_writer.sv
// Randomized bench for ram_stream_writer: a high-level model predicts write sequences,
// completion pulses, counts and checksums for each scenario.
module tb_ram_stream_writer;
   localparam int AW = 19;
   localparam int DW = 8;
   localparam int AMASK = (1 << AW) - 1;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length = '0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, ram_wren, busy, done;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data;
   logic [AW:0]   words_written;
   logic [DW-1:0] checksum;

   ram_stream_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clock(clk), .reset_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
      .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .busy(busy),
      .done(done), .words_written(words_written), .checksum(checksum));

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   int wa[$], wd[$], wc[$], dc[$];
   // reference model
   int m_base, m_len, m_cnt;
   bit m_abort;
   int sent[$], vpat[$], dpat[$];

   always @(negedge clk) begin
      cyc++;
      if (ram_wren === 1'b1) begin
         wa.push_back(int'(ram_address)); wd.push_back(int'(ram_data)); wc.push_back(cyc);
      end
      if (done === 1'b1) dc.push_back(cyc);
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout reached");
      $fatal(1, "timeout");
   end

   task automatic clear_log;
      wa.delete(); wd.delete(); wc.delete(); dc.delete();
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int b, input int len);
      base_addr = AW'(b); length = (AW+1)'(len); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      m_base = b; m_len = len; m_cnt = 0; m_abort = 1'b0; sent.delete();
   endtask

   // Drives the stream until the model says the transfer ended, was aborted, or reached stop_at beats.
   task automatic feed(input int pct, input int abort_at, input int stop_at);
      int guard;
      bit v, a;
      guard = 0;
      while (m_cnt < m_len && !m_abort && m_cnt != stop_at) begin
         a = (m_cnt == abort_at);
         if (vpat.size() > 0) v = (vpat.pop_front() != 0);
         else v = ($urandom_range(0, 99) < pct);
         if (v && dpat.size() > 0) in_data = DW'(dpat.pop_front());
         else in_data = DW'($urandom_range(0, 255));
         in_valid = v; abort = a;
         @(negedge clk);
         n_chk++;
         if (in_ready !== ~a) $display("FAIL in_ready beat=%0d got=%b want=%b", m_cnt, in_ready, ~a);
         else n_pass++;
         @(posedge clk); #1;
         if (a) m_abort = 1'b1;
         else if (v) begin sent.push_back(int'(in_data)); m_cnt++; end
         guard++;
         if (guard > 2000) begin
            n_chk++;
            $display("FAIL feed_timeout got=%0d beats want=%0d", m_cnt, m_len);
            break;
         end
      end
      in_valid = 1'b0; abort = 1'b0;
   endtask

   function automatic int model_sum();
      int s = 0;
      foreach (sent[i]) s += sent[i];
      return s & ((1 << DW) - 1);
   endfunction

   task test_reset;
      rst_n = 1'b0;
      #3;
      n_chk++;
      if ({in_ready, ram_wren, busy, done} !== 4'b0) $display("FAIL reset_flags got=%b want=0000", {in_ready, ram_wren, busy, done});
      else n_pass++;
      n_chk++;
      if ({ram_address, ram_data, words_written, checksum} !== '0)
         $display("FAIL reset_values got addr=%h data=%h ww=%0d cs=%h want all 0", ram_address, ram_data, words_written, checksum);
      else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task test_basic;
      int exp_d[4] = '{'h11, 'h22, 'h33, 'h44};
      clear_log;
      foreach (exp_d[i]) dpat.push_back(exp_d[i]);
      do_start(0, 4);
      feed(100, -1, -1);
      @(negedge clk);
      n_chk++;
      if ({in_ready, busy, ram_wren} !== 3'b011) $display("FAIL basic_flush got rdy/busy/wren=%b want=011", {in_ready, busy, ram_wren});
      else n_pass++;
      settle(3);
      n_chk++;
      if (wa.size() != 4) $display("FAIL basic_count got=%0d want=4", wa.size());
      else begin
         n_pass++;
         for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (wa[i] != i || wd[i] != exp_d[i] || wc[i] != wc[0] + i)
               $display("FAIL basic_write%0d got a=%h d=%h c=%0d want a=%h d=%h c=%0d", i, wa[i], wd[i], wc[i], i, exp_d[i], wc[0] + i);
            else n_pass++;
         end
         n_chk++;
         if (dc.size() != 1 || dc[0] != wc[3] + 1) $display("FAIL basic_done got n=%0d want one pulse at %0d", dc.size(), wc[3] + 1);
         else n_pass++;
      end
      n_chk++;
      if (words_written !== (AW+1)'(4) || checksum !== 8'hAA || busy !== 1'b0)
         $display("FAIL basic_totals got ww=%0d cs=%h busy=%b want 4 aa 0", words_written, checksum, busy);
      else n_pass++;
   endtask

   task test_wrap;
      int exp_a[4] = '{'h7FFFE, 'h7FFFF, 'h00000, 'h00001};
      clear_log;
      do_start('h7FFFE, 4);
      feed(100, -1, -1);
      settle(3);
      n_chk++;
      if (wa.size() != 4) $display("FAIL wrap_count got=%0d want=4", wa.size());
      else begin
         n_pass++;
         for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (wa[i] != exp_a[i] || wd[i] != sent[i]) $display("FAIL wrap_write%0d got a=%h d=%h want a=%h d=%h", i, wa[i], wd[i], exp_a[i], sent[i]);
            else n_pass++;
         end
      end
   endtask

   task test_gaps;
      int b;
      b = $urandom_range(0, AMASK);
      clear_log;
      vpat = '{1, 0, 1, 0, 1};
      do_start(b, 3);
      feed(100, -1, -1);
      settle(3);
      n_chk++;
      if (wa.size() != 3) $display("FAIL gaps_count got=%0d want=3", wa.size());
      else begin
         n_pass++;
         for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (wa[i] != ((b + i) & AMASK) || wd[i] != sent[i] || wc[i] != wc[0] + 2 * i)
               $display("FAIL gaps_write%0d got a=%h c=%0d want a=%h c=%0d", i, wa[i], wc[i], (b + i) & AMASK, wc[0] + 2 * i);
            else n_pass++;
         end
         n_chk++;
         if (dc.size() != 1 || dc[0] != wc[2] + 1) $display("FAIL gaps_done got n=%0d want one pulse at %0d", dc.size(), wc[2] + 1);
         else n_pass++;
      end
   endtask

   task test_abort;
      int b;
      b = $urandom_range(0, AMASK);
      clear_log;
      do_start(b, 10);
      feed(100, -1, 2);
      start = 1'b1; base_addr = '0; length = (AW+1)'(1);
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b1) $display("FAIL abort_busy got=%b want=1", busy);
      else n_pass++;
      @(posedge clk); #1;
      start = 1'b0;
      feed(100, 5, -1);
      settle(3);
      n_chk++;
      if (wa.size() != 5 || dc.size() != 0) $display("FAIL abort_count got writes=%0d dones=%0d want 5 0", wa.size(), dc.size());
      else begin
         n_pass++;
         for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (wa[i] != ((b + i) & AMASK) || wd[i] != sent[i]) $display("FAIL abort_write%0d got a=%h d=%h want a=%h d=%h", i, wa[i], wd[i], (b + i) & AMASK, sent[i]);
            else n_pass++;
         end
      end
      n_chk++;
      if (words_written !== (AW+1)'(5) || checksum !== DW'(model_sum()) || busy !== 1'b0)
         $display("FAIL abort_totals got ww=%0d cs=%h busy=%b want 5 %h 0", words_written, checksum, busy, model_sum());
      else n_pass++;
   endtask

   task test_zero_len;
      clear_log;
      do_start($urandom_range(0, AMASK), 0);
      @(negedge clk);
      n_chk++;
      if ({done, ram_wren, busy} !== 3'b100 || words_written !== '0 || checksum !== '0)
         $display("FAIL zero_len got done/wren/busy=%b ww=%0d cs=%h want 100 0 0", {done, ram_wren, busy}, words_written, checksum);
      else n_pass++;
      settle(2);
      n_chk++;
      if (dc.size() != 1 || wa.size() != 0) $display("FAIL zero_len_log got dones=%0d writes=%0d want 1 0", dc.size(), wa.size());
      else n_pass++;
   endtask

   task test_reset_mid;
      int b2;
      clear_log;
      do_start($urandom_range(0, AMASK), 6);
      feed(100, -1, 2);
      in_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({in_ready, ram_wren, busy, done} !== 4'b0 || {ram_address, ram_data, words_written, checksum} !== '0)
         $display("FAIL reset_mid_outputs got rdy/wren/busy/done=%b addr=%h ww=%0d", {in_ready, ram_wren, busy, done}, ram_address, words_written);
      else n_pass++;
      repeat (3) @(posedge clk);
      n_chk++;
      if (wa.size() != 1) $display("FAIL reset_mid_writes got=%0d want=1", wa.size());
      else n_pass++;
      @(negedge clk); in_valid = 1'b0; rst_n = 1'b1;
      @(posedge clk); #1;
      b2 = $urandom_range(0, AMASK);
      clear_log;
      do_start(b2, 2);
      feed(100, -1, -1);
      settle(3);
      n_chk++;
      if (wa.size() != 2 || dc.size() != 1 || wa[0] != b2 || wa[1] != ((b2 + 1) & AMASK) || wd[0] != sent[0] || wd[1] != sent[1])
         $display("FAIL reset_mid_restart got writes=%0d dones=%0d want 2 writes from %h", wa.size(), dc.size(), b2);
      else n_pass++;
      n_chk++;
      if (words_written !== (AW+1)'(2) || checksum !== DW'(model_sum()))
         $display("FAIL reset_mid_totals got ww=%0d cs=%h want 2 %h", words_written, checksum, model_sum());
      else n_pass++;
   endtask

   task test_random;
      int b, len, ab;
      for (int t = 0; t < 8; t++) begin
         b   = ($urandom_range(0, 1) != 0) ? AMASK - $urandom_range(0, 8) : $urandom_range(0, AMASK);
         len = $urandom_range(1, 16);
         ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
         clear_log;
         do_start(b, len);
         feed($urandom_range(40, 100), ab, -1);
         settle(3);
         n_chk++;
         if (wa.size() != sent.size() || dc.size() != (m_abort ? 0 : 1))
            $display("FAIL rand%0d_count got writes=%0d dones=%0d want %0d %0d", t, wa.size(), dc.size(), sent.size(), m_abort ? 0 : 1);
         else begin
            n_pass++;
            for (int i = 0; i < sent.size(); i++) begin
               n_chk++;
               if (wa[i] != ((b + i) & AMASK) || wd[i] != sent[i])
                  $display("FAIL rand%0d_write%0d got a=%h d=%h want a=%h d=%h", t, i, wa[i], wd[i], (b + i) & AMASK, sent[i]);
               else n_pass++;
            end
         end
         n_chk++;
         if (words_written !== (AW+1)'(m_cnt) || checksum !== DW'(model_sum()))
            $display("FAIL rand%0d_totals got ww=%0d cs=%h want %0d %h", t, words_written, checksum, m_cnt, model_sum());
         else n_pass++;
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_wrap;
      test_gaps;
      test_abort;
      test_zero_len;
      test_reset_mid;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
